// File: rtl/bram_pkg.sv
// Shared encodings for block-RAM port write behaviour.
// Used by tdp_bram_reg and by the blocks that instantiate it.
package bram_pkg;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } bram_mode_e;

endpackage

// File: rtl/tdp_bram_reg.sv
// True dual-port single-clock RAM with a core output register on each port.
// Port A wins same-address write collisions; a reader colliding with a writer sees old data.
module tdp_bram_reg
    import bram_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter bram_mode_e  PORTA_MODE = WRITE_FIRST,
    parameter bram_mode_e  PORTB_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              regcea,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    input  logic              enb,
    input  logic              regceb,
    input  logic              web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] doutb
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Not reset; the BRAM powers up zeroed from the configuration image.
    logic [DATA_W-1:0] mem [0:Depth-1];

    logic [DATA_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_b;

    // B is written first so that A's write to the same address lands last and wins.
    always_ff @(posedge clk) begin
        if (enb && web) begin
            mem[addrb] <= dinb;
        end
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    // Reads sample mem before this edge's writes commit, so collisions return old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a <= '0;
            douta <= '0;
        end else begin
            if (ena) begin
                if (!wea) begin
                    lat_a <= mem[addra];
                end else begin
                    case (PORTA_MODE)
                        WRITE_FIRST: lat_a <= dina;
                        READ_FIRST:  lat_a <= mem[addra];
                        default:     lat_a <= lat_a;
                    endcase
                end
            end
            if (regcea) begin
                douta <= lat_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_b <= '0;
            doutb <= '0;
        end else begin
            if (enb) begin
                if (!web) begin
                    lat_b <= mem[addrb];
                end else begin
                    case (PORTB_MODE)
                        WRITE_FIRST: lat_b <= dinb;
                        READ_FIRST:  lat_b <= mem[addrb];
                        default:     lat_b <= lat_b;
                    endcase
                end
            end
            if (regceb) begin
                doutb <= lat_b;
            end
        end
    end

endmodule

// File: tb/tb_tdp_bram_reg.sv
// Directed bench for tdp_bram_reg: 64K main instance plus a 512-entry XRAY instance.
// Expected read data is queued when an access is issued and compared when it reaches dout.
module tb_tdp_bram_reg;
    import bram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0, regcea = 1'b0, wea = 1'b0;
    logic        enb = 1'b0, regceb = 1'b0, web = 1'b0;
    logic [15:0] addra = '0, addrb = '0;
    logic [7:0]  dina = '0, dinb = '0;
    logic [7:0]  douta, doutb;
    logic [7:0]  x_douta, x_doutb;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qx[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tdp_bram_reg #(
        .DATA_W(8), .ADDR_W(16), .PORTA_MODE(WRITE_FIRST), .PORTB_MODE(READ_FIRST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .regcea(regcea), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
        .enb(enb), .regceb(regceb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
    );

    tdp_bram_reg #(
        .DATA_W(8), .ADDR_W(9), .PORTA_MODE(WRITE_FIRST), .PORTB_MODE(READ_FIRST)
    ) xray (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .regcea(regcea), .wea(wea), .addra(addra[8:0]), .dina(dina),
        .douta(x_douta),
        .enb(enb), .regceb(regceb), .web(web), .addrb(addrb[8:0]), .dinb(dinb),
        .doutb(x_doutb)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input int port, input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        if (port == 0) qa.push_back(e);
        else if (port == 1) qb.push_back(e);
        else qx.push_back(e);
    endtask

    task automatic pop_check(input int port);
        exp_t e;
        logic [7:0] obs;
        if ((port == 0 && qa.size() == 0) || (port == 1 && qb.size() == 0) ||
            (port == 2 && qx.size() == 0)) begin
            n_chk++;
            $error("FAIL scoreboard: observed empty queue expected entry for port %0d", port);
            return;
        end
        if (port == 0) begin e = qa.pop_front(); obs = douta; end
        else if (port == 1) begin e = qb.pop_front(); obs = doutb; end
        else begin e = qx.pop_front(); obs = x_douta; end
        check(e.tag, obs, e.val);
    endtask

    // Drive one cycle of inputs at the falling edge; returns at the next falling edge.
    task automatic step(input logic ea, input logic wa, input logic ra, input logic [15:0] aa,
                        input logic [7:0] da, input logic eb, input logic wb, input logic rb,
                        input logic [15:0] ab, input logic [7:0] db);
        ena = ea; wea = wa; regcea = ra; addra = aa; dina = da;
        enb = eb; web = wb; regceb = rb; addrb = ab; dinb = db;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        push(0, "reset_douta", 8'h00); pop_check(0);
        push(1, "reset_doutb", 8'h00); pop_check(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Port A write-first: douta carries the new data two edges after the write.
        step(1, 1, 0, 16'h8000, 8'hA5, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 1, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        push(0, "a_write_first", 8'hA5); pop_check(0);

        // Latency and hold: seed 0x8001 through B, read on A with regcea low, then pulse it.
        step(0, 0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h8001, 8'h3C);
        step(1, 0, 0, 16'h8001, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        idle();
        push(0, "a_hold_no_regce", 8'hA5); pop_check(0);
        step(0, 0, 1, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        push(0, "a_read_8001", 8'h3C); pop_check(0);
        idle(); idle();
        push(0, "a_hold_after_pulse", 8'h3C); pop_check(0);

        // Port B read-first: write returns the old content, a later read returns the new.
        step(1, 1, 0, 16'h1234, 8'h11, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h1234, 8'h22);
        step(0, 0, 0, 16'h0, 8'h0, 0, 0, 1, 16'h0, 8'h0);
        push(1, "b_read_first_old", 8'h11); pop_check(1);
        step(0, 0, 0, 16'h0, 8'h0, 1, 0, 0, 16'h1234, 8'h0);
        step(0, 0, 0, 16'h0, 8'h0, 0, 0, 1, 16'h0, 8'h0);
        push(1, "b_read_new", 8'h22); pop_check(1);

        // Collisions at 0x0100: A wins write-write; a reader sees old data.
        step(1, 1, 0, 16'h0100, 8'h77, 1, 1, 0, 16'h0100, 8'h88);
        step(0, 0, 0, 16'h0, 8'h0, 1, 0, 0, 16'h0100, 8'h0);
        step(0, 0, 0, 16'h0, 8'h0, 0, 0, 1, 16'h0, 8'h0);
        push(1, "ww_collision", 8'h77); pop_check(1);
        step(1, 0, 0, 16'h0100, 8'h0, 1, 1, 0, 16'h0100, 8'h99);
        step(0, 0, 1, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        push(0, "rw_collision_old", 8'h77); pop_check(0);
        step(0, 0, 0, 16'h0, 8'h0, 1, 0, 0, 16'h0100, 8'h0);
        step(0, 0, 0, 16'h0, 8'h0, 0, 0, 1, 16'h0, 8'h0);
        push(1, "rw_collision_stored", 8'h99); pop_check(1);

        // A write with enable low must be ignored.
        step(1, 1, 1, 16'h8000, 8'h5A, 0, 0, 0, 16'h0, 8'h0);
        step(0, 1, 1, 16'h8000, 8'hFF, 0, 0, 0, 16'h0, 8'h0);
        push(0, "a_write_5a", 8'h5A); pop_check(0);

        // Asynchronous reset mid-run clears outputs between edges; memory survives.
        step(0, 0, 0, 16'h0, 8'h0, 1, 0, 0, 16'h8000, 8'h0);
        step(0, 0, 0, 16'h0, 8'h0, 0, 0, 1, 16'h0, 8'h0);
        push(1, "b_read_5a", 8'h5A); pop_check(1);
        #2 rst_n = 1'b0;
        #1;
        push(0, "midrun_reset_douta", 8'h00); pop_check(0);
        push(1, "midrun_reset_doutb", 8'h00); pop_check(1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 16'h8000, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 1, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        push(0, "after_reset_8000", 8'h5A); pop_check(0);

        // XRAY instance: 0x1FF written on B, read on A; 0x000 keeps its own value.
        step(1, 1, 0, 16'h0000, 8'h12, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h01FF, 8'hEE);
        step(1, 0, 0, 16'h01FF, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 1, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        push(2, "xray_1ff", 8'hEE); pop_check(2);
        step(1, 0, 0, 16'h0000, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        step(0, 0, 1, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
        push(2, "xray_000", 8'h12); pop_check(2);

        idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
